prog_clk_divider: RTL and testbench

PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

---
 rtl/prog_clk_divider.sv | 188 ++++++++++++++++++
 tb/tb_prog_clk_divider.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_clk_divider.sv
// -----------------------------------------------------------------------------
// prog_clk_divider
//
// Programmable clock divider. A phase counter cycles 0..N-1 at the input clock
// rate; clk_out is high for the first H phases of each period and tick pulses
// on phase 0. A newly loaded divisor is held in a shadow register and only
// becomes active at the next period boundary, so the output never produces a
// truncated or stretched period.
//
// Optional feature macro: CLKDIV_DUTY_EN
//   When defined, a duty_val input is added. Its value is shadowed and applied
//   together with div_val, and the active duty sets H directly (0 -> always
//   low, >= N -> always high). Without it, H = floor(N/2).
//
// Parameters
//   CNT_W       width of the phase counter and the divisor/duty fields
//   DEFAULT_DIV divide ratio after reset (values below 2 are raised to 2)
//
// Ports
//   clk_50mhz  in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   enable     in   run/stop of output generation
//   div_val    in   requested divide ratio N (CNT_W bits)
//   div_load   in   one-cycle strobe capturing div_val (and duty_val)
//   duty_val   in   requested high time in input cycles (CLKDIV_DUTY_EN only)
//   clk_out    out  registered divided clock
//   tick       out  registered one-cycle pulse at the start of each period
//   div_busy   out  high while a loaded divisor waits for the period boundary
// -----------------------------------------------------------------------------
module prog_clk_divider #(
   parameter int CNT_W       = 20,
   parameter int DEFAULT_DIV = 500000
) (
   input  logic             clk_50mhz,
   input  logic             rst,
   input  logic             enable,
   input  logic [CNT_W-1:0] div_val,
   input  logic             div_load,
`ifdef CLKDIV_DUTY_EN
   input  logic [CNT_W-1:0] duty_val,
`endif
   output logic             clk_out,
   output logic             tick,
   output logic             div_busy
);

   localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
   localparam logic [CNT_W-1:0] DEF_DIV =
      (DEFAULT_DIV < 2) ? MIN_DIV : CNT_W'(DEFAULT_DIV);
`ifdef CLKDIV_DUTY_EN
   localparam logic [CNT_W-1:0] DEF_DUTY = CNT_W'(DEFAULT_DIV / 2);
`endif

   // ST_STOP: not generating (after reset or while enable is low).
   // ST_RUN : counting; the first enabled cycle after ST_STOP starts a period.
   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_reg,    state_next;
   logic [CNT_W-1:0] phase_reg,    phase_next;
   logic [CNT_W-1:0] div_act_reg,  div_act_next;
   logic [CNT_W-1:0] div_shd_reg,  div_shd_next;
   logic             busy_reg,     busy_next;
   logic             clk_out_reg,  clk_out_next;
   logic             tick_reg,     tick_next;
`ifdef CLKDIV_DUTY_EN
   logic [CNT_W-1:0] duty_act_reg, duty_act_next;
   logic [CNT_W-1:0] duty_shd_reg, duty_shd_next;
`endif

   logic [CNT_W-1:0] div_clamped;
   logic [CNT_W-1:0] high_next;
   logic             period_start;

   assign div_clamped = (div_val < MIN_DIV) ? MIN_DIV : div_val;

   // A new period begins either on restart from ST_STOP or after the last
   // phase of the running period.
   assign period_start = (state_reg == ST_STOP) ||
                         (phase_reg == div_act_reg - CNT_W'(1));

   always_comb begin
      state_next    = state_reg;
      phase_next    = phase_reg;
      div_act_next  = div_act_reg;
      div_shd_next  = div_shd_reg;
      busy_next     = busy_reg;
      clk_out_next  = 1'b0;
      tick_next     = 1'b0;
      high_next     = '0;
`ifdef CLKDIV_DUTY_EN
      duty_act_next = duty_act_reg;
      duty_shd_next = duty_shd_reg;
`endif

      if (!enable) begin
         // Stopped: outputs idle, a pending load stays pending, and a fresh
         // load goes straight to the active registers.
         state_next = ST_STOP;
         phase_next = '0;
         if (div_load) begin
            div_act_next  = div_clamped;
            div_shd_next  = div_clamped;
            busy_next     = 1'b0;
`ifdef CLKDIV_DUTY_EN
            duty_act_next = duty_val;
            duty_shd_next = duty_val;
`endif
         end
      end else begin
         state_next = ST_RUN;
         if (period_start) begin
            phase_next = '0;
            busy_next  = 1'b0;
            // A strobe coinciding with the boundary is newer than anything
            // in the shadow, so it takes effect for the period now starting.
            if (div_load) begin
               div_act_next  = div_clamped;
               div_shd_next  = div_clamped;
`ifdef CLKDIV_DUTY_EN
               duty_act_next = duty_val;
               duty_shd_next = duty_val;
`endif
            end else begin
               div_act_next  = div_shd_reg;
`ifdef CLKDIV_DUTY_EN
               duty_act_next = duty_shd_reg;
`endif
            end
         end else begin
            phase_next = phase_reg + CNT_W'(1);
            // Later strobes in the same period simply overwrite the shadow.
            if (div_load) begin
               div_shd_next  = div_clamped;
               busy_next     = 1'b1;
`ifdef CLKDIV_DUTY_EN
               duty_shd_next = duty_val;
`endif
            end
         end

`ifdef CLKDIV_DUTY_EN
         high_next = duty_act_next;
`else
         high_next = div_act_next >> 1;
`endif
         // Outputs are computed from next-state values so the registered
         // outputs line up with the phase held in the same cycle.
         clk_out_next = (phase_next < high_next);
         tick_next    = (phase_next == '0);
      end
   end

   always_ff @(posedge clk_50mhz) begin
      if (rst) begin
         state_reg    <= ST_STOP;
         phase_reg    <= '0;
         div_act_reg  <= DEF_DIV;
         div_shd_reg  <= DEF_DIV;
         busy_reg     <= 1'b0;
         clk_out_reg  <= 1'b0;
         tick_reg     <= 1'b0;
`ifdef CLKDIV_DUTY_EN
         duty_act_reg <= DEF_DUTY;
         duty_shd_reg <= DEF_DUTY;
`endif
      end else begin
         state_reg    <= state_next;
         phase_reg    <= phase_next;
         div_act_reg  <= div_act_next;
         div_shd_reg  <= div_shd_next;
         busy_reg     <= busy_next;
         clk_out_reg  <= clk_out_next;
         tick_reg     <= tick_next;
`ifdef CLKDIV_DUTY_EN
         duty_act_reg <= duty_act_next;
         duty_shd_reg <= duty_shd_next;
`endif
      end
   end

   assign clk_out  = clk_out_reg;
   assign tick     = tick_reg;
   assign div_busy = busy_reg;

endmodule

// File: tb/tb_prog_clk_divider.sv
// -----------------------------------------------------------------------------
// tb_prog_clk_divider
//
// Self-checking bench for prog_clk_divider (CNT_W=8, DEFAULT_DIV=10).
// A period-level reference model predicts clk_out, tick and div_busy for every
// cycle; directed steps add explicit checks on period lengths and busy time.
// Honours CLKDIV_DUTY_EN when defined.
// -----------------------------------------------------------------------------
module tb_prog_clk_divider;

   localparam int CNT_W = 8;
   localparam int DEF   = 10;

   logic             clk_50mhz = 1'b0;
   logic             rst       = 1'b1;
   logic             enable    = 1'b1;
   logic [CNT_W-1:0] div_val   = '0;
   logic             div_load  = 1'b0;
`ifdef CLKDIV_DUTY_EN
   logic [CNT_W-1:0] duty_val  = '0;
`endif
   logic             clk_out;
   logic             tick;
   logic             div_busy;

   prog_clk_divider #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
      .clk_50mhz (clk_50mhz),
      .rst       (rst),
      .enable    (enable),
      .div_val   (div_val),
      .div_load  (div_load),
`ifdef CLKDIV_DUTY_EN
      .duty_val  (duty_val),
`endif
      .clk_out   (clk_out),
      .tick      (tick),
      .div_busy  (div_busy)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   // Reference model: period length, high time, pending request, position
   int m_na, m_ns, m_da, m_ds, m_phase;
   bit m_pend, m_act;
   bit e_clk, e_tick, e_busy;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int last_tick_cyc = 0;
   int last_gap      = 0;

   function automatic int clampd(input int v);
      return (v < 2) ? 2 : v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
      end
   endtask

   // Applies the rules for one rising edge using the inputs held at that edge.
   task automatic model_step();
      int dv;
      int high;
`ifdef CLKDIV_DUTY_EN
      dv = int'(duty_val);
`else
      dv = 0;
`endif
      if (rst) begin
         m_na = DEF; m_ns = DEF; m_da = DEF / 2; m_ds = DEF / 2;
         m_pend = 0; m_act = 0; m_phase = 0;
         e_clk = 0; e_tick = 0; e_busy = 0;
      end else if (!enable) begin
         if (div_load) begin
            m_na = clampd(int'(div_val)); m_ns = m_na;
            m_da = dv; m_ds = dv; m_pend = 0;
         end
         m_phase = 0; m_act = 0;
         e_clk = 0; e_tick = 0; e_busy = m_pend;
      end else begin
         if (!m_act || m_phase == m_na - 1) begin
            if (div_load) begin
               m_na = clampd(int'(div_val)); m_da = dv;
            end else if (m_pend) begin
               m_na = m_ns; m_da = m_ds;
            end
            m_pend  = 0;
            m_phase = 0;
         end else begin
            m_phase++;
            if (div_load) begin
               m_ns = clampd(int'(div_val)); m_ds = dv; m_pend = 1;
            end
         end
         m_act = 1;
`ifdef CLKDIV_DUTY_EN
         high = m_da;
`else
         high = m_na / 2;
`endif
         e_clk  = (m_phase < high);
         e_tick = (m_phase == 0);
         e_busy = m_pend;
      end
   endtask

   task automatic cycle();
      @(posedge clk_50mhz);
      model_step();
      #1;
      cyc++;
      if (tick === 1'b1) begin
         last_gap      = cyc - last_tick_cyc;
         last_tick_cyc = cyc;
      end
      chk("clk_out",  clk_out,  e_clk);
      chk("tick",     tick,     e_tick);
      chk("div_busy", div_busy, e_busy);
      div_load = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic load(input int n, input int d);
      div_val  = CNT_W'(n);
`ifdef CLKDIV_DUTY_EN
      duty_val = CNT_W'(d);
`endif
      div_load = 1'b1;
      $display("load div=%0d duty=%0d enable=%0b at model phase %0d", n, d, enable, m_phase);
      cycle();
   endtask

   // Advances until the current cycle's model phase equals t.
   task automatic wait_phase(input int t);
      int k = 0;
      while ((m_phase != t || !m_act) && k < 300) begin
         cycle();
         k++;
      end
      chk("wait_phase_in_budget", (k < 300), 1);
   endtask

   initial begin
      int cnt;
      int k;

      // Reset / default ratio
      rst = 1'b1; enable = 1'b1;
      run(5);
      chk("reset_clk_out", clk_out, 0);
      chk("reset_busy",    div_busy, 0);
      rst = 1'b0;
      cycle();
      chk("first_tick_after_reset", tick, 1);
      run(29);
      chk("default_period", last_gap, 10);
      $display("default ratio run done");

      // Odd and clamped ratios
      load(7, 3);
      wait_phase(0); run(7);
      chk("period_7", last_gap, 7);
      load(1, 1);
      wait_phase(0); run(2);
      chk("period_clamp_1", last_gap, 2);
      load(0, 1);
      run(3); wait_phase(0); run(2);
      chk("period_clamp_0", last_gap, 2);

      // Glitch-free change: strobe sampled at the edge that advances p to 3
      load(10, 5);
      run(25);
      wait_phase(2);
      load(4, 2);
      cnt = 0; k = 0;
      while (div_busy === 1'b1 && k < 40) begin
         cnt++; cycle(); k++;
      end
      chk("busy_cycles", cnt, 7);
      chk("old_period_complete", last_gap, 10);
      run(4);
      chk("new_period_4", last_gap, 4);

      // Multiple loads in one period, then a load on the last phase
      wait_phase(1);
      load(6, 3);
      load(8, 4);
      wait_phase(0); run(8);
      chk("last_load_wins", last_gap, 8);
      wait_phase(7);
      load(5, 2);
      chk("boundary_load_not_busy", div_busy, 0);
      run(5);
      chk("boundary_load_period", last_gap, 5);

      // Enable drop / re-raise, reset with pending load
      load(10, 5);
      run(12);
      wait_phase(4);
      enable = 1'b0;
      cycle();
      chk("disabled_clk_out", clk_out, 0);
      chk("disabled_tick",    tick, 0);
      run(3);
      enable = 1'b1;
      cycle();
      chk("reenable_tick", tick, 1);
      wait_phase(1);
      load(3, 1);
      chk("pending_busy", div_busy, 1);
      rst = 1'b1;
      cycle();
      chk("reset_clears_busy", div_busy, 0);
      rst = 1'b0;
      cycle();
      run(10);
      chk("reset_restores_default", last_gap, 10);

      // Load while disabled goes straight to the active ratio
      enable = 1'b0;
      run(2);
      load(6, 3);
      chk("disabled_load_busy", div_busy, 0);
      enable = 1'b1;
      cycle(); run(6);
      chk("disabled_load_period", last_gap, 6);

`ifdef CLKDIV_DUTY_EN
      load(10, 3);
      run(30);
      chk("duty3_period", last_gap, 10);
      load(10, 0);
      run(30);
      chk("duty0_low", clk_out, 0);
      load(10, 12);
      run(30);
      chk("duty12_high", clk_out, 1);
      chk("duty12_period", last_gap, 10);
`endif

      // Randomised operation against the model
      $display("random phase start");
      for (int i = 0; i < 500; i++) begin
         rst    = ($urandom_range(0, 99) == 0);
         enable = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 7) == 0) begin
            div_val  = CNT_W'($urandom_range(0, 20));
`ifdef CLKDIV_DUTY_EN
            duty_val = CNT_W'($urandom_range(0, 22));
`endif
            div_load = 1'b1;
         end
         cycle();
      end
      rst = 1'b0; enable = 1'b1;
      run(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
